// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/FETCH/WAIT fetch FSM, PC, IF/ID register.
// Ports: clk/rst, hazard controls, redirect inputs, imem handshake, IF/ID outputs, stats.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcwrite,
    input  logic        if_id_write,
    input  logic [1:0]  pcsrc,
    input  logic        if_id_reg_flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [5:0]  OPC,
    output logic [5:0]  func,
    output logic [4:0]  if_id_rs,
    output logic [4:0]  if_id_rt,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_bubbles
);

    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    state_t      state;
    if_id_t      if_id;
    logic        br_sel;
    logic        jmp_sel;
    logic        redirect;
    logic        accept;
    logic        bubble;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign imem_req  = (state != BOOT);
    assign imem_addr = pc;

    assign br_sel   = pcwrite & (pcsrc == 2'b01);
    assign jmp_sel  = pcwrite & (pcsrc == 2'b10);
    assign redirect = br_sel | jmp_sel;
    // Redirect wins: the in-flight word belongs to the wrong path.
    assign accept   = imem_req & imem_ready & if_id_write
                    & pcwrite & ~redirect;
    assign bubble   = if_id_write & (if_id_reg_flush | ~accept);

    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {if_id.pc_plus4[31:28],
                          if_id.instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc;
        unique case (1'b1)
            br_sel:  next_pc = branch_target & ~32'h3;
            jmp_sel: next_pc = jump_target;
            accept:  next_pc = pc_plus4;
            default: next_pc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= BOOT;
            pc           <= RESET_PC & ~32'h3;
            if_id        <= '0;
            stat_fetched <= '0;
            stat_bubbles <= '0;
        end else begin
            unique case (state)
                BOOT:    state <= FETCH;
                FETCH:   state <= imem_ready ? FETCH : WAIT;
                WAIT:    state <= (imem_ready | redirect) ? FETCH : WAIT;
                default: state <= BOOT;
            endcase
            pc <= next_pc;
            if (bubble) begin
                if_id        <= '0;
                stat_bubbles <= stat_bubbles + 32'd1;
            end else if (accept) begin
                if_id <= '{instr: imem_rdata,
                           pc_plus4: pc_plus4,
                           valid: 1'b1};
            end
            if (accept)
                stat_fetched <= stat_fetched + 32'd1;
        end
    end

    assign if_id_instr    = if_id.instr;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_valid    = if_id.valid;

    assign OPC      = if_id.instr[31:26];
    assign func     = if_id.instr[5:0];
    assign if_id_rs = if_id.instr[25:21];
    assign if_id_rt = if_id.instr[20:16];

endmodule
